// File: rtl/fetch_stage.sv
// fetch_stage: PC and IF/ID register with stall, redirect squash and HALT detection
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter logic [5:0]  HALT_OPCODE = 6'h0A,
    parameter logic [31:0] NOP_WORD    = 32'h0,
    parameter int          CNT_W       = 16
) (
    input  logic             clk_pi,
    input  logic             reset_pi,
    input  logic             stall_pi,
    input  logic             redirect_pi,
    input  logic [31:0]      redirect_target_pi,
    input  logic [31:0]      instruction_pi,
    output logic [31:0]      pc_po,
    output logic [31:0]      if_id_instr_po,
    output logic [31:0]      if_id_pc4_po,
    output logic             if_id_valid_po,
    output logic             halted_po,
    output logic [CNT_W-1:0] fetch_count_po
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d;
    logic             valid_q, valid_d, halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pc_plus4;
    logic             is_halt, fetch, bubble;
    assign pc_plus4 = pc_q + 32'd4;
    assign is_halt  = instruction_pi[31:26] == HALT_OPCODE;
    assign fetch    = state_q == RUN && !stall_pi && !redirect_pi;
    assign bubble   = redirect_pi || (!stall_pi && state_q == HALTED);
    // Next-state: redirect beats stall beats fetch; a HALT word is latched but freezes the PC
    always_comb begin
        pc_d     = redirect_pi ? {redirect_target_pi[31:2], 2'b00} : (fetch && !is_halt) ? pc_plus4 : pc_q;
        instr_d  = bubble ? NOP_WORD : fetch ? instruction_pi : instr_q;
        pc4_d    = bubble ? 32'd0 : fetch ? pc_plus4 : pc4_q;
        valid_d  = bubble ? 1'b0 : fetch ? 1'b1 : valid_q;
        cnt_d    = (fetch && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
        state_d  = redirect_pi ? RUN : (fetch && is_halt) ? HALTED : state_q;
        halted_d = state_d == HALTED;
    end
    // Pipeline state and FSM registers, asynchronously reset
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            pc_q     <= RESET_PC;
            instr_q  <= NOP_WORD;
            pc4_q    <= 32'd0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end
    assign pc_po          = pc_q;
    assign if_id_instr_po = instr_q;
    assign if_id_pc4_po   = pc4_q;
    assign if_id_valid_po = valid_q;
    assign halted_po      = halted_q;
    assign fetch_count_po = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus random fetch sequences checked against a reference model
module tb_fetch_stage;
    localparam int CW = 4;
    logic          clk_pi = 0, reset_pi = 1, stall_pi = 0, redirect_pi = 0;
    logic [31:0]   redirect_target_pi = 0, instruction_pi;
    logic [31:0]   pc_po, if_id_instr_po, if_id_pc4_po;
    logic          if_id_valid_po, halted_po;
    logic [CW-1:0] fetch_count_po;
    logic [31:0]   mem [0:63];
    logic [31:0]   m_pc, m_instr, m_pc4, w;
    logic          m_valid, m_halt;
    logic [CW-1:0] m_cnt;
    int            checks = 0, failures = 0;

    fetch_stage #(.CNT_W(CW)) dut (
        .clk_pi(clk_pi), .reset_pi(reset_pi), .stall_pi(stall_pi), .redirect_pi(redirect_pi),
        .redirect_target_pi(redirect_target_pi), .instruction_pi(instruction_pi), .pc_po(pc_po),
        .if_id_instr_po(if_id_instr_po), .if_id_pc4_po(if_id_pc4_po), .if_id_valid_po(if_id_valid_po),
        .halted_po(halted_po), .fetch_count_po(fetch_count_po)
    );

    always #5 clk_pi = ~clk_pi;
    assign instruction_pi = mem[pc_po[7:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc", pc_po, m_pc);
        chk("if_id_instr", if_id_instr_po, m_instr);
        chk("if_id_pc4", if_id_pc4_po, m_pc4);
        chk("if_id_valid", {31'd0, if_id_valid_po}, {31'd0, m_valid});
        chk("halted", {31'd0, halted_po}, {31'd0, m_halt});
        chk("fetch_count", {{(32-CW){1'b0}}, fetch_count_po}, {{(32-CW){1'b0}}, m_cnt});
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halt = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        if (redirect_pi) begin
            m_pc = redirect_target_pi & ~32'd3;
            m_instr = 0; m_pc4 = 0; m_valid = 0; m_halt = 0;
        end else if (!stall_pi) begin
            if (m_halt) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else begin
                w = mem[m_pc[7:2]];
                m_instr = w; m_pc4 = m_pc + 4; m_valid = 1;
                if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
                if (w[31:26] == 6'h0A) m_halt = 1;
                else m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_pi);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2 reset_pi = 1;
        #1 model_reset();
        check_all();
        #1 reset_pi = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h15080005; mem[1] = 32'h10200000; mem[2] = 32'h14210001; mem[6] = 32'h28000000;
        #12 reset_pi = 0;
        model_reset();
        check_all();
        repeat (2) cycle();
        stall_pi = 1;
        repeat (2) cycle();
        stall_pi = 0;
        repeat (4) cycle();
        redirect_pi = 1; stall_pi = 1; redirect_target_pi = 32'h6;
        cycle();
        redirect_pi = 0; stall_pi = 0;
        repeat (6) cycle();
        repeat (2) cycle();
        mem[6] = 32'h0;
        redirect_pi = 1; redirect_target_pi = 32'd24;
        cycle();
        redirect_pi = 0;
        repeat (2) cycle();
        redirect_pi = 1; redirect_target_pi = 32'hFFFFFFFC;
        cycle();
        redirect_pi = 0;
        cycle();
        repeat (16) cycle();
        stall_pi = 1; redirect_pi = 1;
        async_reset();
        stall_pi = 0; redirect_pi = 0;
        for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 5) == 0) ? {6'h0A, 26'($urandom)} : $urandom;
        for (int n = 0; n < 400; n++) begin
            stall_pi = $urandom_range(0, 3) == 0;
            redirect_pi = $urandom_range(0, 7) == 0;
            redirect_target_pi = $urandom;
            if ($urandom_range(0, 49) == 0) async_reset();
            else cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline; owns the program counter (PC) and the IF/ID pipeline register.
- Drives the PC to the combinational instruction memory and captures the returned word into IF/ID.
- Handles stall from hazard detection, branch redirect/squash from the branch-resolving stage, and HALT detection.
- Next PC = PC+4; branch target is computed downstream (PC+4+offset) and delivered here.

Parameters:
RESET_PC, 32'h0, PC value loaded on reset.
HALT_OPCODE, 6'h0A, instruction[31:26] value identifying HALT.
NOP_WORD, 32'h0, instruction word inserted into IF/ID as a bubble.
CNT_W, 16, width of the fetch counter.

Ports:
clk_pi  in  1  clock; all state updates on rising edge.
reset_pi  in  1  asynchronous, active-high reset.
stall_pi  in  1  hold PC and IF/ID (load-use hazard).
redirect_pi  in  1  taken branch resolved downstream; squash fetch path.
redirect_target_pi  in  32  new PC when redirect_pi=1.
instruction_pi  in  32  word returned by instruction memory for pc_po (same cycle, combinational).
pc_po  out  32  current PC to instruction memory.
if_id_instr_po  out  32  IF/ID instruction.
if_id_pc4_po  out  32  IF/ID PC+4 of that instruction.
if_id_valid_po  out  1  IF/ID holds a real instruction.
halted_po  out  1  fetch has stopped on HALT.
fetch_count_po  out  CNT_W  number of valid instructions loaded into IF/ID.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0, state=RUN, halted_po=0, fetch_count=0.
- States: RUN, HALTED. halted_po = (state==HALTED), registered.
- Priority each edge: redirect_pi > stall_pi > normal fetch.
- Redirect (either state): pc <= {redirect_target_pi[31:2],2'b00}; IF/ID <= bubble (NOP_WORD, pc4=0, valid=0); state <= RUN; count unchanged. Overrides a simultaneous stall and a simultaneous HALT fetch.
- Stall, no redirect: pc, IF/ID, state, count all hold.
- RUN, no stall/redirect: IF/ID <= {instruction_pi, pc+4, valid=1}; count += 1 (saturates at all-ones).
  - instruction_pi[31:26] != HALT_OPCODE: pc <= pc+4 (mod 2^32; 32'hFFFFFFFC wraps to 0).
  - == HALT_OPCODE: pc holds; state <= HALTED next edge. The HALT word itself is latched valid.
- HALTED, no stall/redirect: pc holds; IF/ID <= bubble; count holds.
- Fetch latency: word at pc_po appears on if_id_* one edge later.
- Bubble encoding: NOP_WORD is also the instruction memory default, so wrong-path/out-of-range fetches decode as no-ops downstream.
- Reset asserted mid-stall or mid-redirect: reset wins, same values as above.

Test Plan:
- Sequential fetch: reset, then memory returns 32'h15080005 @0, 32'h10200000 @4, 32'h14210001 @8 -> pc_po 0,4,8,12 on successive edges; IF/ID = (15080005,4,1), (10200000,8,1), (14210001,12,1); fetch_count 1,2,3.
- Stall: at pc=8, hold stall_pi high 2 cycles -> pc_po stays 8, IF/ID stays (10200000,8,1), count stays 2; after release pc_po=12 next edge.
- Redirect with stall: at pc=24, assert redirect_pi+stall_pi, target 32'h6 -> pc_po=4, if_id_valid=0, if_id_instr=0; next edge fetches @4 with valid=1.
- HALT: memory returns 32'h28000000 @24 -> IF/ID=(28000000,28,1), pc_po stays 24, halted_po=1 next edge; further edges give valid=0, count frozen.
- Squashed HALT: in HALTED, assert redirect_pi with target 24'd… 32'd24 (program-2 CONTINUE) -> halted_po=0, pc_po=24, bubble in IF/ID, fetch resumes.
- Wrap and async reset: force redirect to 32'hFFFFFFFC, fetch nop -> pc_po=0; assert reset_pi between edges -> all outputs at reset values without a clock edge.
